// File: rtl/bootdata_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bootdata_pkg                                                    |
// | Purpose  : Shared types and constants for the boot-ROM download sender.   |
// |            Holds the transfer state encoding, the word/counter widths    |
// |            and the default image length. The default image length is the |
// |            size of the bootloader's ROM window (0x5C000..0x7FFFF).        |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package bootdata_pkg;

  // Word delivered to the bootloader and width of the image byte counter.
  localparam int BOOT_WORD_W = 32;
  localparam int BOOT_CNT_W  = 19;
  localparam int BOOT_LANES  = BOOT_WORD_W / 8;

  // ROM window written by the bootloader; END is exclusive.
  localparam int unsigned BOOT_ROM_BASE = 32'h0005_C000;
  localparam int unsigned BOOT_ROM_END  = 32'h0008_0000;

  // Default image length must match the bootloader's ROM window exactly,
  // otherwise host_rom_initialised is never raised (or is raised early).
  localparam int unsigned BOOT_IMAGE_BYTES_DEFAULT = BOOT_ROM_END - BOOT_ROM_BASE;

  // Transfer states, explicit 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_REQ  = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } boot_state_e;

  // A transfer is in progress in every state between start and completion.
  function automatic logic is_busy_state(input boot_state_e s);
    return (s == ST_FILL) || (s == ST_REQ) || (s == ST_GAP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bootdata_word_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bootdata_word_packer                                            |
// | Purpose  : Packs accepted image bytes into a 32-bit little-endian word.   |
// |            Byte k of a word lands on bits [8k+7:8k]. When the image's     |
// |            final byte arrives before the word is full, the remaining      |
// |            upper lanes are loaded with PAD_BYTE in the same cycle, so the |
// |            word is complete on the edge the sender raises its request.   |
// | Ports    : clk, reset_n   - clock, asynchronous active-low reset          |
// |            clear          - restart packing at lane 0                     |
// |            wr_en          - an image byte is accepted this cycle          |
// |            last_byte      - the accepted byte is the image's final byte   |
// |            wr_data[7:0]   - the accepted byte                             |
// |            word[31:0]     - registered packed word                        |
// |            word_full      - this accept completes the current word        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module bootdata_word_packer
  import bootdata_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE = 8'hFF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   wr_en,
  input  logic                   last_byte,
  input  logic [7:0]             wr_data,
  output logic [BOOT_WORD_W-1:0] word,
  output logic                   word_full
);

  localparam logic [1:0] LAST_LANE = 2'(BOOT_LANES - 1);

  logic [1:0]             lane_d;
  logic [1:0]             lane_q;
  logic [BOOT_WORD_W-1:0] word_d;
  logic [BOOT_WORD_W-1:0] word_q;

  // Lane pointer wraps naturally after lane 3; after the image's last byte
  // it is forced back to 0 so a partial final word leaves no stale offset.
  always_comb begin
    lane_d = lane_q;
    if (clear) begin
      lane_d = 2'd0;
    end else if (wr_en) begin
      lane_d = last_byte ? 2'd0 : (lane_q + 2'd1);
    end
  end

  // Per-lane write: the addressed lane takes the data byte; on the final
  // byte every higher lane takes the pad value; all others hold.
  for (genvar i = 0; i < BOOT_LANES; i++) begin : g_lane
    localparam logic [1:0] LANE_IDX = 2'(i);
    logic wr_here;
    logic pad_here;
    assign wr_here  = wr_en && (lane_q == LANE_IDX);
    assign pad_here = wr_en && last_byte && (LANE_IDX > lane_q);
    assign word_d[8*i +: 8] = wr_here  ? wr_data  :
                              pad_here ? PAD_BYTE :
                                         word_q[8*i +: 8];
  end

  assign word_full = wr_en && (last_byte || (lane_q == LAST_LANE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_q <= 2'd0;
      word_q <= '0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
    end
  end

  assign word = word_q;

endmodule
`default_nettype wire

// File: rtl/bootdata_sender.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bootdata_sender                                                 |
// | Purpose  : Host-side boot-ROM download transmitter. Pulls image bytes     |
// |            from the storage reader, packs them four to a word and hands  |
// |            each word to the core bootloader over a req/ack handshake.    |
// |            Stops after IMAGE_BYTES bytes; a partial last word is padded. |
// | Ports    : clk, reset_n        - clock, asynchronous active-low reset     |
// |            start               - pulse, begins a transfer from IDLE/DONE  |
// |            src_data/valid      - byte stream from the storage reader      |
// |            src_ready           - byte accepted this cycle (state decode)  |
// |            host_bootdata[31:0] - packed word, first byte on [7:0]         |
// |            host_bootdata_req   - word valid, held until acknowledged      |
// |            host_bootdata_ack   - pulse, word consumed by the bootloader   |
// |            busy                - transfer in progress                     |
// |            done                - whole image delivered (sticky)           |
// |            byte_count[18:0]    - image bytes accepted so far              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module bootdata_sender
  import bootdata_pkg::*;
#(
  parameter int unsigned IMAGE_BYTES = BOOT_IMAGE_BYTES_DEFAULT,
  parameter logic [7:0]  PAD_BYTE    = 8'hFF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [7:0]             src_data,
  input  logic                   src_valid,
  output logic                   src_ready,
  output logic [BOOT_WORD_W-1:0] host_bootdata,
  output logic                   host_bootdata_req,
  input  logic                   host_bootdata_ack,
  output logic                   busy,
  output logic                   done,
  output logic [BOOT_CNT_W-1:0]  byte_count
);

  localparam logic [BOOT_CNT_W-1:0] IMAGE_CNT   = BOOT_CNT_W'(IMAGE_BYTES);
  // One bit wider so the "next count" compare cannot wrap at 2^19-1.
  localparam logic [BOOT_CNT_W:0]   IMAGE_CNT_X = {1'b0, IMAGE_CNT};
  localparam logic [BOOT_CNT_W:0]   ONE_X       = (BOOT_CNT_W + 1)'(1);
  localparam logic [BOOT_CNT_W-1:0] ONE         = BOOT_CNT_W'(1);

  boot_state_e           state_d;
  boot_state_e           state_q;
  logic [BOOT_CNT_W-1:0] byte_count_d;
  logic [BOOT_CNT_W-1:0] byte_count_q;
  logic                  req_d;
  logic                  req_q;
  logic                  busy_d;
  logic                  busy_q;
  logic                  done_d;
  logic                  done_q;

  logic                  accept;
  logic                  last_byte;
  logic                  restart;
  logic                  word_full;

  // src_ready depends only on the state register, so there is no
  // combinational path from any input to any output.
  assign src_ready = (state_q == ST_FILL);
  assign accept    = src_valid && src_ready;

  // Decide "final byte" from the count before it increments, so the sender
  // closes the word on that byte and never pulls one past the image.
  assign last_byte = (({1'b0, byte_count_q} + ONE_X) == IMAGE_CNT_X);

  // start is honoured only when no transfer is running.
  assign restart = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_comb begin
    state_d      = state_q;
    byte_count_d = byte_count_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_FILL;
          byte_count_d = '0;
        end
      end
      ST_FILL: begin
        if (accept) begin
          byte_count_d = byte_count_q + ONE;
          if (word_full) begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (host_bootdata_ack) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        // One cycle with req low so the bootloader sees an edge per word.
        state_d = (byte_count_q == IMAGE_CNT) ? ST_DONE : ST_FILL;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs are registered copies of the next-state decode, which
  // keeps them aligned with the state register without extra latency.
  always_comb begin
    req_d  = (state_d == ST_REQ);
    busy_d = is_busy_state(state_d);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      byte_count_q <= '0;
      req_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_count_q <= byte_count_d;
      req_q        <= req_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  bootdata_word_packer #(
    .PAD_BYTE (PAD_BYTE)
  ) u_packer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (restart),
    .wr_en     (accept),
    .last_byte (last_byte),
    .wr_data   (src_data),
    .word      (host_bootdata),
    .word_full (word_full)
  );

  assign host_bootdata_req = req_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign byte_count        = byte_count_q;

endmodule
`default_nettype wire
